// File: rtl/frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : frame_loader (with game_state_pkg)
// Description : Assembles a board bitmap from a byte stream into a back buffer
//               and swaps it into the front frame on a vertical-sync pulse.
//               Optional macro FRAME_LOADER_CHECKSUM_EN adds a trailing XOR
//               checksum byte and the CHECK state.
// Revision    : 1.0 - initial release
// ============================================================================

package game_state_pkg;
    localparam int SCREEN_W = 10;
    localparam int SCREEN_H = 20;

    typedef struct packed {
        logic [15:0]                       score;
        logic [7:0]                        level;
        logic [SCREEN_W-1:0][SCREEN_H-1:0] screen;
    } game_state_t;
endpackage

module frame_loader #(
    parameter int          BOARD_W    = 10,
    parameter int          BOARD_H    = 20,
    parameter logic [7:0]  START_BYTE = 8'hA5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       frame_sync,
    output game_state_pkg::game_state_t frame,
    output logic [7:0]                 frame_count,
    output logic [7:0]                 err_count,
    output logic                       pending
);

    localparam int NUM_CELLS = BOARD_W * BOARD_H;
    localparam int NUM_BYTES = (NUM_CELLS + 7) / 8;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(NUM_BYTES - 1);

`ifdef FRAME_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_HUNT      = 3'd0,
        S_PAYLOAD   = 3'd1,
        S_CHECK     = 3'd2,
        S_COMMIT    = 3'd3,
        S_WAIT_SWAP = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_HUNT      = 3'd0,
        S_PAYLOAD   = 3'd1,
        S_COMMIT    = 3'd3,
        S_WAIT_SWAP = 3'd4
    } state_t;
`endif

    state_t                          r_state;
    state_t                          w_next;
    logic [CNT_W-1:0]                r_cnt;
    logic [NUM_CELLS-1:0]            w_back;
    logic [NUM_CELLS-1:0]            r_front;
    logic [7:0]                      r_frame_count;
    logic                            r_pending;
    logic                            w_in_ready;
    logic                            w_start;
    logic                            w_load;
    logic                            w_commit;
    logic                            w_swap;
    logic [BOARD_W-1:0][BOARD_H-1:0] w_screen;
`ifdef FRAME_LOADER_CHECKSUM_EN
    logic [7:0]                      r_csum;
    logic [7:0]                      r_err_count;
    logic                            w_reject;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_start    = 1'b0;
        w_load     = 1'b0;
        w_commit   = 1'b0;
        w_swap     = 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
        w_reject   = 1'b0;
`endif
        case (r_state)
            S_HUNT: begin
                w_in_ready = 1'b1;
                if (in_valid && (in_data == START_BYTE)) begin
                    w_start = 1'b1;
                    w_next  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                // A header byte value inside the payload is ordinary data.
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_load = 1'b1;
                    if (r_cnt == c_LAST_IDX) begin
`ifdef FRAME_LOADER_CHECKSUM_EN
                        w_next = S_CHECK;
`else
                        w_next = S_COMMIT;
`endif
                    end
                end
            end
`ifdef FRAME_LOADER_CHECKSUM_EN
            S_CHECK: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data == r_csum) begin
                        w_next = S_COMMIT;
                    end else begin
                        w_reject = 1'b1;
                        w_next   = S_HUNT;
                    end
                end
            end
`endif
            S_COMMIT: begin
                // A sync pulse coinciding with this cycle is deliberately ignored.
                w_commit = 1'b1;
                w_next   = S_WAIT_SWAP;
            end
            S_WAIT_SWAP: begin
                if (frame_sync) begin
                    w_swap = 1'b1;
                    w_next = S_HUNT;
                end
            end
            default: begin
                w_next = S_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_pending     <= 1'b0;
            r_frame_count <= 8'd0;
            r_front       <= '0;
        end else begin
            if (w_start) begin
                r_cnt <= '0;
            end else if (w_load) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_commit) begin
                r_pending <= 1'b1;
            end else if (w_swap) begin
                r_pending <= 1'b0;
            end
            if (w_swap) begin
                r_front       <= w_back;
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

`ifdef FRAME_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_csum      <= 8'd0;
            r_err_count <= 8'd0;
        end else begin
            if (w_start) begin
                r_csum <= 8'd0;
            end else if (w_load) begin
                r_csum <= r_csum ^ in_data;
            end
            if (w_reject && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 8'd0;
`endif

    // The final byte only stores the bits that map onto real cells.
    genvar k;
    generate
        for (k = 0; k < NUM_BYTES; k++) begin : g_back
            localparam int c_LO = k * 8;
            localparam int c_NB = ((NUM_CELLS - c_LO) < 8) ? (NUM_CELLS - c_LO) : 8;

            logic [c_NB-1:0] r_byte;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_byte <= '0;
                end else if (w_load && (r_cnt == CNT_W'(k))) begin
                    r_byte <= in_data[c_NB-1:0];
                end
            end

            assign w_back[c_LO +: c_NB] = r_byte;
        end
    endgenerate

    genvar gx, gy;
    generate
        for (gx = 0; gx < BOARD_W; gx++) begin : g_col
            for (gy = 0; gy < BOARD_H; gy++) begin : g_row
                assign w_screen[gx][gy] = r_front[gy * BOARD_W + gx];
            end
        end
    endgenerate

    always_comb begin
        frame        = '0;
        frame.screen = w_screen;
    end

    assign in_ready    = w_in_ready;
    assign pending     = r_pending;
    assign frame_count = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_loader
// Description : Randomized self-checking bench for frame_loader against a
//               cell-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_frame_loader;
    import game_state_pkg::*;

    localparam int         W     = 10;
    localparam int         H     = 20;
    localparam int         NC    = W * H;
    localparam int         NB    = (NC + 7) / 8;
    localparam logic [7:0] START = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        frame_sync;
    game_state_t frame;
    logic [7:0]  frame_count;
    logic [7:0]  err_count;
    logic        pending;

    frame_loader #(
        .BOARD_W    (W),
        .BOARD_H    (H),
        .START_BYTE (START)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .frame_sync  (frame_sync),
        .frame       (frame),
        .frame_count (frame_count),
        .err_count   (err_count),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [NC-1:0] m_front;
    logic [NC-1:0] m_back;
    logic [7:0] m_fc;
    logic [7:0] m_ec;
    bit         m_pending;
    logic [7:0] payload [NB];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic game_state_t model_frame();
        game_state_t f;
        f = '0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                f.screen[x][y] = m_front[y * W + x];
        return f;
    endfunction

    function automatic logic [7:0] payload_xor();
        logic [7:0] s;
        s = 8'd0;
        for (int k = 0; k < NB; k++) s = s ^ payload[k];
        return s;
    endfunction

    task automatic model_reset();
        m_front   = '0;
        m_back    = '0;
        m_fc      = 8'd0;
        m_ec      = 8'd0;
        m_pending = 1'b0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < NB; k++) payload[k] = 8'($urandom);
    endtask

    task automatic push(input logic [7:0] b, input bit noise);
        int gap;
        int t;
        bit acc;
        gap = noise ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < gap; i++) begin
            in_valid   = 1'b0;
            frame_sync = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
        end
        frame_sync = 1'b0;
        in_valid   = 1'b1;
        in_data    = b;
        acc        = 1'b0;
        t          = 0;
        while (!acc && t < 200) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            else t++;
        end
        if (!acc) check("push_timeout", 256'd0, 256'd1);
        else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] csum, input bit noise);
        bit ok;
        push(START, noise);
        for (int k = 0; k < NB; k++) push(payload[k], noise);
`ifdef FRAME_LOADER_CHECKSUM_EN
        push(csum, noise);
        ok = (csum == payload_xor());
`else
        ok = (csum == csum);
`endif
        if (ok) begin
            for (int i = 0; i < NC; i++) m_back[i] = payload[i / 8][i % 8];
            m_pending = 1'b1;
        end else if (m_ec != 8'hFF) begin
            m_ec = m_ec + 8'd1;
        end
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_swap();
        @(negedge clk);
        frame_sync = 1'b1;
        @(posedge clk);
        #1;
        frame_sync = 1'b0;
        if (m_pending) begin
            m_front   = m_back;
            m_fc      = m_fc + 8'd1;
            m_pending = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_frame"}, 256'(frame), 256'(model_frame()));
        check({tag, "_pending"}, 256'(pending), 256'(m_pending));
        check({tag, "_frame_count"}, 256'(frame_count), 256'(m_fc));
        check({tag, "_err_count"}, 256'(err_count), 256'(m_ec));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        logic [7:0] cs;

        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        frame_sync = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        check("reset_in_ready", 256'(in_ready), 256'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // All-ones-in-bit-0 frame: cells 0, 8, ..., 192 set.
        for (int k = 0; k < NB; k++) payload[k] = 8'h01;
        send_frame(8'h01, 1'b0);
        settle();
        check_all("t1_before_sync");
        do_swap();
        check_all("t1_after_sync");
        check("t1_cell_0_0", 256'(frame.screen[0][0]), 256'd1);
        check("t1_cell_8_0", 256'(frame.screen[8][0]), 256'd1);
        check("t1_cell_6_1", 256'(frame.screen[6][1]), 256'd1);
        check("t1_cell_2_19", 256'(frame.screen[2][19]), 256'd1);
        check("t1_cell_1_0", 256'(frame.screen[1][0]), 256'd0);

        // Garbage ahead of a header is ignored.
        push(8'h00, 1'b0);
        push(8'hFF, 1'b0);
        push(8'h3C, 1'b0);
        fill_random();
        send_frame(payload_xor(), 1'b0);
        settle();
        do_swap();
        check_all("t2_garbage");

`ifdef FRAME_LOADER_CHECKSUM_EN
        for (int k = 0; k < NB; k++) payload[k] = 8'h01;
        send_frame(8'h00, 1'b0);
        settle();
        check_all("t3_bad_csum");
        check("t3_in_ready", 256'(in_ready), 256'd1);
        do_swap();
        check_all("t3_sync_ignored");
`endif

        // Back-pressure while a frame waits for its swap.
        fill_random();
        send_frame(payload_xor(), 1'b0);
        settle();
        in_valid = 1'b1;
        in_data  = 8'h00;
        hi       = 0;
        repeat (100) begin
            @(negedge clk);
            if (in_ready) hi++;
        end
        check("t4_ready_low_cycles", 256'(hi), 256'd0);
        check("t4_pending_held", 256'(pending), 256'd1);
        frame_sync = 1'b1;
        @(posedge clk);
        #1;
        frame_sync = 1'b0;
        m_front    = m_back;
        m_fc       = m_fc + 8'd1;
        m_pending  = 1'b0;
        @(negedge clk);
        check("t4_ready_after_swap", 256'(in_ready), 256'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_all("t4_after_swap");

        // Sync coinciding with COMMIT is not honoured; header value inside payload is data.
        fill_random();
        payload[3] = START;
        send_frame(payload_xor(), 1'b0);
        frame_sync = 1'b1;
        @(posedge clk);
        #1;
        frame_sync = 1'b0;
        check_all("t5_commit_sync");
        do_swap();
        check_all("t5_next_sync");

        // Randomized frames with idle gaps, stray syncs, leading garbage.
        for (int it = 0; it < 6; it++) begin
            int ng;
            logic [7:0] g;
            ng = int'($urandom_range(0, 3));
            for (int j = 0; j < ng; j++) begin
                g = 8'($urandom);
                if (g == START) g = 8'h5A;
                push(g, 1'b1);
            end
            fill_random();
            cs = payload_xor();
`ifdef FRAME_LOADER_CHECKSUM_EN
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
`endif
            send_frame(cs, 1'b1);
            settle();
            check_all("t6_pre_sync");
            do_swap();
            check_all("t6_post_sync");
        end

        // Reset mid-payload.
        fill_random();
        push(START, 1'b0);
        for (int k = 0; k < 10; k++) push(payload[k], 1'b0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("t7_in_reset");
        check("t7_in_ready", 256'(in_ready), 256'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        fill_random();
        send_frame(payload_xor(), 1'b0);
        settle();
        do_swap();
        check_all("t7_reload");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
